// File: rtl/mc_main_control.sv
// mc_main_control: multi-cycle MIPS main control FSM (3-5 cycles per instruction).
// Optional MEM_WAIT_EN: FETCH/MEMRD/MEMWR stretch until mem_ready.
module mc_main_control #(
   parameter int ILLEGAL_HALT = 0,
   parameter int STATE_W      = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [5:0]         opcode,
   input  logic               mem_ready,
   output logic               pcwrite,
   output logic               pcwritecond,
   output logic               iord,
   output logic               memread,
   output logic               memwrite,
   output logic               irwrite,
   output logic               memtoreg,
   output logic               regdst,
   output logic               regwrite,
   output logic               alusrca,
   output logic [1:0]         alusrcb,
   output logic [1:0]         aluop,
   output logic [1:0]         pcsrc,
   output logic               illegal_op,
   output logic [STATE_W-1:0] state_o
);
   typedef enum logic [STATE_W-1:0] {
      FETCH  = 0,
      DECODE = 1,
      MEMADR = 2,
      MEMRD  = 3,
      MEMWB  = 4,
      MEMWR  = 5,
      REX    = 6,
      ALUWB  = 7,
      BEQ    = 8,
      ADDIEX = 9,
      IMMWB  = 10,
      JUMP   = 11,
      ORIEX  = 12,
      RST    = 13,
      HALT   = 15
   } state_t;
   state_t state;
   logic   rdy;
`ifdef MEM_WAIT_EN
   assign rdy = mem_ready;
`else
   logic unused_mem_ready;
   assign rdy = 1'b1;
   assign unused_mem_ready = mem_ready;
`endif
   assign state_o = state;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= RST;
         illegal_op <= 1'b0;
      end else begin
         illegal_op <= 1'b0;
         case (state)
            RST:    state <= FETCH;
            FETCH:  state <= rdy ? DECODE : FETCH;
            DECODE: begin
               case (opcode)
                  6'd0:         state <= REX;
                  6'd35, 6'd43: state <= MEMADR;
                  6'd4:         state <= BEQ;
                  6'd8:         state <= ADDIEX;
                  6'd13:        state <= ORIEX;
                  6'd2:         state <= JUMP;
                  default: begin
                     state      <= (ILLEGAL_HALT != 0) ? HALT : FETCH;
                     illegal_op <= 1'b1;
                  end
               endcase
            end
            MEMADR: state <= (opcode == 6'd35) ? MEMRD : MEMWR;
            MEMRD:  state <= rdy ? MEMWB : MEMRD;
            MEMWR:  state <= rdy ? FETCH : MEMWR;
            REX:    state <= ALUWB;
            ADDIEX, ORIEX: state <= IMMWB;
            MEMWB, ALUWB, IMMWB, BEQ, JUMP: state <= FETCH;
            HALT:   state <= HALT;
            default: state <= FETCH;
         endcase
      end
   end
   // Moore decode; only the FETCH strobes see mem_ready so a stalled fetch bumps the PC once
   always_comb begin
      pcwrite     = 1'b0;
      pcwritecond = 1'b0;
      iord        = 1'b0;
      memread     = 1'b0;
      memwrite    = 1'b0;
      irwrite     = 1'b0;
      memtoreg    = 1'b0;
      regdst      = 1'b0;
      regwrite    = 1'b0;
      alusrca     = 1'b0;
      alusrcb     = 2'd0;
      aluop       = 2'd0;
      pcsrc       = 2'd0;
      case (state)
         FETCH: begin
            memread = 1'b1;
            irwrite = rdy;
            pcwrite = rdy;
            alusrcb = 2'd1;
         end
         DECODE: alusrcb = 2'd3;
         MEMADR, ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'd2;
         end
         ORIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'd2;
            aluop   = 2'd3;
         end
         MEMRD: begin
            memread = 1'b1;
            iord    = 1'b1;
         end
         MEMWR: begin
            memwrite = 1'b1;
            iord     = 1'b1;
         end
         MEMWB: begin
            regwrite = 1'b1;
            memtoreg = 1'b1;
         end
         REX: begin
            alusrca = 1'b1;
            aluop   = 2'd2;
         end
         ALUWB: begin
            regwrite = 1'b1;
            regdst   = 1'b1;
         end
         IMMWB: regwrite = 1'b1;
         BEQ: begin
            alusrca     = 1'b1;
            aluop       = 2'd1;
            pcsrc       = 2'd1;
            pcwritecond = 1'b1;
         end
         JUMP: begin
            pcwrite = 1'b1;
            pcsrc   = 2'd2;
         end
         default: ;
      endcase
   end
endmodule

// File: doc/mc_main_control.md
Name: mc_main_control

Overview:
- Multi-cycle main control FSM for the MIPS datapath.
- Takes the 6-bit instruction opcode held in the IR and sequences one instruction over 3-5 cycles.
- Produces all datapath enables and muxes, including the 2-bit aluop consumed by the ALU control decoder: 0=add, 1=sub, 2=use funct, 3=ori-logic.
- Sits between the instruction register and the datapath; one instance per core.

Parameters:
- ILLEGAL_HALT, 0: unsupported opcode in DECODE. 0 = pulse illegal_op and return to FETCH; 1 = enter HALT until reset.
- STATE_W, 4: width of the state register and the state_o debug port (must be >=4).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- opcode  in  6  IR[31:26], stable outside FETCH.
- mem_ready  in  1  memory done handshake; used only under MEM_WAIT_EN.
- pcwrite  out  1  unconditional PC write.
- pcwritecond  out  1  PC write if ALU zero.
- iord  out  1  memory address select: 0=PC, 1=ALUOut.
- memread  out  1  memory read strobe.
- memwrite  out  1  memory write strobe.
- irwrite  out  1  IR load.
- memtoreg  out  1  register write-data select: 1=MDR.
- regdst  out  1  destination register select: 1=rd, 0=rt.
- regwrite  out  1  register file write.
- alusrca  out  1  ALU A select: 0=PC, 1=A.
- alusrcb  out  2  ALU B select: 0=B, 1=const 4, 2=signext imm, 3=signext imm<<2.
- aluop  out  2  to ALU control decoder.
- pcsrc  out  2  PC source: 0=ALU, 1=ALUOut, 2=jump target.
- illegal_op  out  1  one-cycle pulse on an unsupported opcode.
- state_o  out  STATE_W  current state, for debug.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- Moore FSM. All outputs except illegal_op are decoded from the state register only. illegal_op is registered.
- Reset: state=RST(13), illegal_op=0, all outputs 0. First clock after rst_n deasserts goes to FETCH.
- Reset mid-instruction aborts immediately: no further strobes are issued and the next clock after deassertion starts from RST.
- State encodings: FETCH0 DECODE1 MEMADR2 MEMRD3 MEMWB4 MEMWR5 REX6 ALUWB7 BEQ8 ADDIEX9 IMMWB10 JUMP11 ORIEX12 RST13 HALT15.
- Outputs per state; any signal not listed is 0:
  - FETCH: memread, irwrite, pcwrite, alusrcb=1, aluop=0, pcsrc=0.
  - DECODE: alusrcb=3, aluop=0.
  - MEMADR, ADDIEX: alusrca=1, alusrcb=2, aluop=0.
  - ORIEX: alusrca=1, alusrcb=2, aluop=3.
  - MEMRD: memread, iord.
  - MEMWR: memwrite, iord.
  - MEMWB: regwrite, memtoreg.
  - REX: alusrca=1, alusrcb=0, aluop=2.
  - ALUWB: regwrite, regdst.
  - IMMWB: regwrite.
  - BEQ: alusrca=1, aluop=1, pcsrc=1, pcwritecond.
  - JUMP: pcwrite, pcsrc=2.
  - HALT, RST: all 0.
- Transitions:
  - FETCH->DECODE.
  - DECODE by opcode: 0->REX, 35(lw)/43(sw)->MEMADR, 4(beq)->BEQ, 8(addi)->ADDIEX, 13(ori)->ORIEX, 2(j)->JUMP, other->illegal.
  - MEMADR: opcode 35 ->MEMRD, else ->MEMWR.
  - MEMRD->MEMWB.
  - REX->ALUWB.
  - ADDIEX, ORIEX->IMMWB.
  - MEMWB, MEMWR, ALUWB, IMMWB, BEQ, JUMP->FETCH.
  - HALT->HALT.
- Illegal opcode: illegal_op=1 for exactly the cycle after DECODE. Next state is FETCH (ILLEGAL_HALT=0) or HALT (ILLEGAL_HALT=1).
- Unreachable encodings (14, or any value >15) go to FETCH on the next clock with all outputs 0.
- Cycle counts: lw 5, sw 4, R-type 4, addi/ori 4, beq 3, j 3.
- Decode reads opcode only in DECODE and MEMADR; changes to opcode in other states are ignored.

Optional Feature:
- Macro: MEM_WAIT_EN.
- Defined:
  - FETCH, MEMRD and MEMWR hold while mem_ready=0.
  - In FETCH, irwrite and pcwrite are gated by mem_ready, so each fetch increments the PC exactly once.
  - memread/memwrite/iord stay asserted throughout the wait.
- Undefined: mem_ready is ignored and every memory state lasts exactly one cycle.

Test Plan:
- Reset then opcode=35: states 13,0,1,2,3,4,0. regwrite=1 and memtoreg=1 only in the MEMWB cycle; aluop=0 in MEMADR.
- opcode=0: states 0,1,6,7. aluop=2 in REX; regdst=1 and regwrite=1 in ALUWB; next state FETCH.
- opcode=4, then opcode=13: BEQ cycle has pcwritecond=1, pcsrc=1, aluop=1. ORIEX cycle has aluop=3, alusrcb=2.
- opcode=63 with ILLEGAL_HALT=0: illegal_op pulses for 1 cycle and the FSM returns to FETCH. With ILLEGAL_HALT=1: state_o=15 and is held for 20 cycles with all outputs 0.
- opcode=43, rst_n pulled low during MEMWR: memwrite drops to 0 asynchronously in the same cycle. After release: RST then FETCH.
- MEM_WAIT_EN, opcode=35, mem_ready low for 3 cycles in FETCH and 2 in MEMRD: pcwrite is high for exactly 1 cycle; total instruction time is 10 cycles.
